engine_sample_sequencer: RTL

ENGINE_SAMPLE_SEQUENCER -- requirements
Module: engine_sample_sequencer

---
 rtl/engine_sample_sequencer_pkg.sv | 20 ++
 rtl/engine_sample_sequencer_seq_watchdog.sv | 40 ++++
 rtl/engine_sample_sequencer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/engine_sample_sequencer_pkg.sv
// engine_sample_sequencer_pkg
// Shared definitions for the engine sample sequencer:
//   - state_t   : sequencer state encodings (IDLE, GAIN, SETTLE, PROCESS, MIX)
//   - sat_inc8  : saturating 8-bit increment used by the dropped-frame counter
package engine_sample_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GAIN    = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_PROCESS = 3'd3,
    ST_MIX     = 3'd4
  } state_t;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

endpackage

// File: rtl/engine_sample_sequencer_seq_watchdog.sv
// seq_watchdog
// Per-state watchdog. The counter restarts whenever the sequencer enters a
// new state and saturates at limit-1; expire flags the cycle in which the
// current state has been resident for limit cycles.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   clear  : high in the first cycle of a new state
//   expire : combinational, high when the residency limit is reached
module seq_watchdog #(
  parameter int unsigned limit = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  localparam int unsigned CW = $clog2(limit);
  localparam logic [CW-1:0] LAST = CW'(limit - 1);

  logic [CW-1:0] count;

  // Residency counter. The entry cycle itself counts as 0 (masked through
  // clear below), so the register restarts at 1 for the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= CW'(1);
    end else if (count != LAST) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign expire = !clear && (count == LAST);

endmodule

// File: rtl/engine_sample_sequencer.sv
// engine_sample_sequencer
// Walks one frame of samples channel by channel through an external gain
// stage, a set of pipelines and a mixer, then publishes the mixed frame.
// Ports:
//   clk, reset                   : clock and asynchronous active-high reset
//   in_samples, sample_ready     : input frame (ch0 at LSBs) and strobe
//   ready                        : high while idle
//   chan_sel                     : channel currently in flight
//   gain_sample/gain_valid       : request to the gain stage
//   gain_done/gain_result        : gain stage response
//   pipe_sample/pipe_tick        : gained sample and start pulse to pipelines
//   pipe_ready                   : per-pipeline idle flags
//   mix_valid, mix_done/result   : mixer request and response
//   out_samples/out_valid        : completed frame and its update pulse
//   clear_errors                 : clears overrun, timeout, overrun_count
//   overrun/overrun_count        : sticky dropped-frame flag, saturating count
//   timeout                      : sticky watchdog-abort flag
//   sample_ctr                   : accepted-frame count (wraps)
module engine_sample_sequencer
  import engine_sample_sequencer_pkg::*;
#(
  parameter int unsigned data_width     = 16,
  parameter int unsigned n_io_channels  = 2,
  parameter int unsigned n_pipelines    = 2,
  parameter int unsigned timeout_cycles = 4096,
  localparam int unsigned CW = (n_io_channels > 1) ? $clog2(n_io_channels) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [n_io_channels*data_width-1:0]  in_samples,
  input  logic                                 sample_ready,
  output logic                                 ready,
  output logic [CW-1:0]                        chan_sel,
  output logic [data_width-1:0]                gain_sample,
  output logic                                 gain_valid,
  input  logic                                 gain_done,
  input  logic [data_width-1:0]                gain_result,
  output logic [data_width-1:0]                pipe_sample,
  output logic                                 pipe_tick,
  input  logic [n_pipelines-1:0]               pipe_ready,
  output logic                                 mix_valid,
  input  logic                                 mix_done,
  input  logic [data_width-1:0]                mix_result,
  output logic [n_io_channels*data_width-1:0]  out_samples,
  output logic                                 out_valid,
  input  logic                                 clear_errors,
  output logic                                 overrun,
  output logic                                 timeout,
  output logic [7:0]                           overrun_count,
  output logic [63:0]                          sample_ctr
);

  localparam logic [CW-1:0] LAST_CH = CW'(n_io_channels - 1);

  state_t                  state;
  logic                    state_entry;
  logic                    wd_expire;
  logic [data_width-1:0]   frame [n_io_channels];
  logic [data_width-1:0]   slots [n_io_channels];
  logic [CW-1:0]           chan_next;
  logic [n_io_channels*data_width-1:0] frame_out;

  assign chan_next = chan_sel + CW'(1);

  seq_watchdog #(.limit(timeout_cycles)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_entry),
    .expire (wd_expire)
  );

  // Completed frame: earlier channels from the slots, the last channel taken
  // straight from the mixer so out_samples updates in the same cycle.
  always_comb begin
    frame_out = '0;
    for (int i = 0; i < int'(n_io_channels); i++) begin
      frame_out[i*data_width +: data_width] =
        (CW'(i) == chan_sel) ? mix_result : slots[i];
    end
  end

  // Sequencer FSM with registered strobes, error flags and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      state_entry   <= 1'b0;
      ready         <= 1'b1;
      chan_sel      <= '0;
      gain_sample   <= '0;
      gain_valid    <= 1'b0;
      pipe_sample   <= '0;
      pipe_tick     <= 1'b0;
      mix_valid     <= 1'b0;
      out_samples   <= '0;
      out_valid     <= 1'b0;
      overrun       <= 1'b0;
      timeout       <= 1'b0;
      overrun_count <= 8'd0;
      sample_ctr    <= 64'd0;
      for (int i = 0; i < int'(n_io_channels); i++) begin
        frame[i] <= '0;
        slots[i] <= '0;
      end
    end else begin
      gain_valid  <= 1'b0;
      pipe_tick   <= 1'b0;
      mix_valid   <= 1'b0;
      out_valid   <= 1'b0;
      state_entry <= 1'b0;

      // A new error in the same cycle as clear_errors wins: the later
      // assignments below override the clear.
      if (clear_errors) begin
        overrun       <= 1'b0;
        timeout       <= 1'b0;
        overrun_count <= 8'd0;
      end else begin
        overrun       <= overrun;
        timeout       <= timeout;
        overrun_count <= overrun_count;
      end
      if (sample_ready && (state != ST_IDLE)) begin
        overrun       <= 1'b1;
        overrun_count <= clear_errors ? 8'd1 : sat_inc8(overrun_count);
      end else begin
        overrun       <= clear_errors ? 1'b0 : overrun;
      end

      case (state)
        ST_IDLE: begin
          if (sample_ready) begin
            for (int i = 0; i < int'(n_io_channels); i++) begin
              frame[i] <= in_samples[i*data_width +: data_width];
            end
            chan_sel    <= '0;
            gain_sample <= in_samples[data_width-1:0];
            gain_valid  <= 1'b1;
            sample_ctr  <= sample_ctr + 64'd1;
            ready       <= 1'b0;
            state       <= ST_GAIN;
            state_entry <= 1'b1;
          end else begin
            ready <= 1'b1;
          end
        end
        ST_GAIN: begin
          if (wd_expire) begin
            timeout     <= 1'b1;
            ready       <= 1'b1;
            state       <= ST_IDLE;
            state_entry <= 1'b1;
          end else if (gain_done) begin
            pipe_sample <= gain_result;
            pipe_tick   <= 1'b1;
            state       <= ST_SETTLE;
            state_entry <= 1'b1;
          end else begin
            state <= ST_GAIN;
          end
        end
        // Gives the pipelines a cycle to drop ready after the tick.
        ST_SETTLE: begin
          state       <= ST_PROCESS;
          state_entry <= 1'b1;
        end
        ST_PROCESS: begin
          if (wd_expire) begin
            timeout     <= 1'b1;
            ready       <= 1'b1;
            state       <= ST_IDLE;
            state_entry <= 1'b1;
          end else if (&pipe_ready) begin
            mix_valid   <= 1'b1;
            state       <= ST_MIX;
            state_entry <= 1'b1;
          end else begin
            state <= ST_PROCESS;
          end
        end
        ST_MIX: begin
          if (wd_expire) begin
            timeout     <= 1'b1;
            ready       <= 1'b1;
            state       <= ST_IDLE;
            state_entry <= 1'b1;
          end else if (mix_done) begin
            slots[chan_sel] <= mix_result;
            state_entry     <= 1'b1;
            if (chan_sel != LAST_CH) begin
              chan_sel    <= chan_next;
              gain_sample <= frame[chan_next];
              gain_valid  <= 1'b1;
              state       <= ST_GAIN;
            end else begin
              out_samples <= frame_out;
              out_valid   <= 1'b1;
              ready       <= 1'b1;
              state       <= ST_IDLE;
            end
          end else begin
            state <= ST_MIX;
          end
        end
        default: begin
          ready       <= 1'b1;
          state       <= ST_IDLE;
          state_entry <= 1'b1;
        end
      endcase
    end
  end

endmodule
